mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- E-stage multiply/divide unit; the producer end of the hi/lo path that the E/M pipeline register latches as hi_E/lo_E.
- Executes mult/multu/div/divu with fixed multi-cycle latency and handles mthi/mtlo writes.
- Holds the architectural HI/LO registers.
- Exposes busy so the hazard unit can stall any hi/lo-touching instruction in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  E-stage instruction is an MDU op; sampled at the rising edge
- op  input  3  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 7 is treated as NONE
- a  input  32  rs operand (forwarded value)
- b  input  32  rt operand (forwarded value)
- busy  output  1  registered; high while an operation is in flight
- hi  output  32  HI register; drives hi_E
- lo  output  32  LO register; drives lo_E

Behaviour:
- Reset (asynchronous, any cycle including mid-operation):
  - hi=0, lo=0, busy=0, counter=0.
  - Pending results are discarded.
- Accept condition: start=1 and busy=0 at a rising edge. When busy=1, start and op are ignored entirely, including MTHI/MTLO; the hazard unit stalls these ops.
- MULT/MULTU:
  - At the accept edge, latch pend_hi/pend_lo = 64-bit product. MULT is signed×signed; MULTU is unsigned×unsigned. pend_hi = bits[63:32], pend_lo = bits[31:0].
  - Load counter = MULT_CYCLES.
- DIV/DIVU:
  - pend_lo = quotient, pend_hi = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign (e.g. -7/2 gives lo=-3, hi=-1).
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
  - Load counter = DIV_CYCLES.
  - Divide by zero (b=0): counter is still loaded and busy still asserted, but hi/lo keep their prior values at completion.
- Counter and completion:
  - busy = (counter != 0), registered.
  - counter decrements once per cycle.
  - On the edge where counter goes 1→0: hi<=pend_hi, lo<=pend_lo (unless divide by zero).
  - busy is therefore high for exactly N cycles after the accept edge, and new hi/lo are visible in the same cycle busy falls.
  - Back-to-back: a start accepted in the first cycle with busy=0 begins a new operation; there are no idle cycles.
- MTHI/MTLO:
  - Single cycle; no busy.
  - At the accept edge, hi<=a (MTHI) or lo<=a (MTLO); the other register is unchanged.
- NONE or start=0: no state change.
- Operands are latched at the accept edge; later changes on a/b do not affect the in-flight result.
- Outputs hi/lo change only at reset, at MTHI/MTLO accept, or at completion. There are no combinational paths from a/b/start to any output.

Test Plan:
- Reset sweep: assert reset asynchronously mid-cycle → hi=lo=0 and busy=0 immediately. Release reset, then MULT a=3 b=4 → busy high 5 cycles; then hi=0, lo=12.
- Signed multiply: MULT a=0xFFFFFFFF b=2 → after 5 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- Divide: DIV a=0xFFFFFFF9 (-7) b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1.
- Divide-by-zero and overflow:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV b=0 → busy 10 cycles; hi/lo remain 0x11/0x22.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy ignoring: start MULT 5×6. At cycle 2 assert MTHI a=0xDEAD and also DIV 9/3 → both ignored; completion gives hi=0, lo=30. A MTLO issued in the cycle busy falls is accepted.
- Mid-op reset and operand hold: start DIVU 100/7 and change a/b the next cycle → result lo=14, hi=2. Repeat with reset asserted in cycle 4 → busy=0 and hi=lo=0, with no later writeback.

Source files
------------

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit holding the architectural HI/LO registers.
// Multi-cycle ops finish after a fixed latency; busy lets the hazard unit stall hi/lo users.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_div0;
  logic             accept;
  logic             is_mult;
  logic             is_div;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] sdiv_b;
  logic [31:0] udiv_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] udq;
  logic [31:0] udr;

  assign accept  = start && !busy;
  assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);

  // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000;
  // a zero divisor is replaced by 1 only to keep the divider defined, its result is discarded.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    abs_a  = a[31] ? (~a + 32'd1) : a;
    abs_b  = b[31] ? (~b + 32'd1) : b;
    sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    udiv_b = (b == 32'd0) ? 32'd1 : b;
    uq     = abs_a / sdiv_b;
    ur     = abs_a % sdiv_b;
    sq     = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    sr     = a[31] ? (~ur + 32'd1) : ur;
    udq    = a / udiv_b;
    udr    = a % udiv_b;
  end

  always_comb begin
    counter_next = counter;
    if (accept && is_mult)
      counter_next = CNT_W'(MULT_CYCLES);
    else if (accept && is_div)
      counter_next = CNT_W'(DIV_CYCLES);
    else if (counter != '0)
      counter_next = counter - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_div0 <= 1'b0;
    end else begin
      counter <= counter_next;
      busy    <= (counter_next != '0);
      if (accept) begin
        case (op)
          OP_MULT: begin
            {pend_hi, pend_lo} <= prod_s;
            pend_div0          <= 1'b0;
          end
          OP_MULTU: begin
            {pend_hi, pend_lo} <= prod_u;
            pend_div0          <= 1'b0;
          end
          OP_DIV: begin
            pend_hi   <= sr;
            pend_lo   <= sq;
            pend_div0 <= (b == 32'd0);
          end
          OP_DIVU: begin
            pend_hi   <= udr;
            pend_lo   <= udq;
            pend_div0 <= (b == 32'd0);
          end
          OP_MTHI: hi <= a;
          OP_MTLO: lo <= a;
          default: ;
        endcase
      end else if (counter == CNT_W'(1) && !pend_div0) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: a reference model pushes expected HI/LO to a queue
// at issue time, and results are popped and compared when busy drops.
module tb_mdu_hilo;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_hilo #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural reference using 64-bit native arithmetic.
  function automatic void modelStep(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MULT: begin
        p = 64'(sx * sy);
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      DIV: if (y != 32'd0) begin
        q = sx / sy;
        r = sx % sy;
        model_lo = q[31:0];
        model_hi = r[31:0];
      end
      DIVU: if (y != 32'd0) begin
        model_lo = x / y;
        model_hi = x % y;
      end
      MTHI: model_hi = x;
      MTLO: model_lo = x;
      default: ;
    endcase
  endfunction

  // Called at a negedge: drives one op for a single accept edge, returns at the following negedge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = NONE;
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int cycles);
    logic [63:0] e;
    int          n;
    modelStep(o, x, y);
    exp_q.push_back({model_hi, model_lo});
    applyStimulus(o, x, y);
    n = 0;
    while (busy && n < 200) begin
      n++;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    checkOutput({tag, "_busy"}, 32'(n), 32'(cycles));
    e = exp_q.pop_front();
    checkOutput({tag, "_hi"}, hi, e[63:32]);
    checkOutput({tag, "_lo"}, lo, e[31:0]);
  endtask

  initial begin
    logic [63:0] e;
    int          n;
    logic [2:0]  rop;
    int          rcyc;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    runOp("mthi_pre", MTHI, 32'h0000_1234, 32'd0, 0);
    applyStimulus(MULT, 32'd7, 32'd8);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_hi", hi, 32'd0);
    checkOutput("async_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    @(negedge clk);

    runOp("mult_3x4", MULT, 32'd3, 32'd4, MULT_CYCLES);
    runOp("mult_neg", MULT, 32'hFFFF_FFFF, 32'd2, MULT_CYCLES);
    runOp("multu_big", MULTU, 32'hFFFF_FFFF, 32'd2, MULT_CYCLES);
    runOp("div_neg7", DIV, 32'hFFFF_FFF9, 32'd2, DIV_CYCLES);
    runOp("divu_7", DIVU, 32'd7, 32'd2, DIV_CYCLES);
    runOp("mthi_11", MTHI, 32'h11, 32'd0, 0);
    runOp("mtlo_22", MTLO, 32'h22, 32'd0, 0);
    runOp("div_zero", DIV, 32'd5, 32'd0, DIV_CYCLES);
    checkOutput("div_zero_hi_kept", hi, 32'h11);
    checkOutput("div_zero_lo_kept", lo, 32'h22);
    runOp("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYCLES);

    // Ops issued while busy must be ignored entirely.
    modelStep(MULT, 32'd5, 32'd6);
    exp_q.push_back({model_hi, model_lo});
    applyStimulus(MULT, 32'd5, 32'd6);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 1) begin
        start = 1'b1; op = MTHI; a = 32'hDEAD; b = 32'd0;
      end else if (n == 2) begin
        start = 1'b1; op = DIV; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0; op = NONE;
      end
      @(negedge clk);
    end
    start = 1'b0;
    op    = NONE;
    checkOutput("ignore_busy", 32'(n), 32'(MULT_CYCLES));
    e = exp_q.pop_front();
    checkOutput("ignore_hi", hi, e[63:32]);
    checkOutput("ignore_lo", lo, e[31:0]);
    runOp("mtlo_fall", MTLO, 32'h55, 32'd0, 0);
    checkOutput("mtlo_fall_hi_kept", hi, 32'd0);

    runOp("divu_100_7", DIVU, 32'd100, 32'd7, DIV_CYCLES);

    applyStimulus(DIVU, 32'd100, 32'd7);
    a = 32'd1;
    b = 32'd1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midop_rst_busy", 32'(busy), 32'd0);
    checkOutput("midop_rst_hi", hi, 32'd0);
    checkOutput("midop_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (15) @(negedge clk);
    checkOutput("midop_late_busy", 32'(busy), 32'd0);
    checkOutput("midop_late_hi", hi, 32'd0);
    checkOutput("midop_late_lo", lo, 32'd0);

    runOp("op7_none", 3'd7, 32'hABCD, 32'h1234, 0);
    for (int i = 0; i < 8; i++) begin
      rop  = 3'($urandom_range(1, 6));
      rcyc = (rop == MULT || rop == MULTU) ? MULT_CYCLES :
             (rop == DIV || rop == DIVU) ? DIV_CYCLES : 0;
      runOp($sformatf("rand%0d", i), rop, $urandom, $urandom, rcyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
